// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter: FSM state encoding.
package timer_arbiter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one down-counter among NUM_REQ requesters; round-robin grant,
// count the winner's delay to zero, then pulse done for that requester.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] delay_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   win_grant;
  logic [IDX_W-1:0]     win_idx;
  logic [WIDTH-1:0]     delay_sel;
  logic [IDX_W-1:0]     ptr_after_owner;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx)
  );

  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(win_idx) == i) delay_sel = delay_i[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_after_owner = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = COUNT;
          owner_d = win_idx;
          grant_d = win_grant;
          count_d = delay_sel;
        end
      end
      COUNT: begin
        // An owner dropping its request aborts before any expiry check.
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          ptr_d   = ptr_after_owner;
        end else if (count_q == '0) begin
          state_d = DONE;
          grant_d = '0;
          done_d  = grant_q;
          ptr_d   = ptr_after_owner;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares a single WIDTH-bit down-counter between NUM_REQ requesters, each asking for a timed delay. Arbitration is round-robin. The winner's delay is loaded into the counter and counted down to zero, then a one-cycle done pulse goes to that requester. The block sits between the requesting control blocks and the shared counter resource. It is the scheduler that sequences the counter instead of letting it free-run.

## Interface
- WIDTH, 4, counter and per-request delay width in bits.
- NUM_REQ, 4, number of requesters (≥2).

- clock_i  input  1  single clock; all state changes on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request level; held high until done_o or abort.
- delay_i  input  NUM_REQ*WIDTH  packed delays; requester i uses bits [i*WIDTH +: WIDTH].
- grant_o  output  NUM_REQ  one-hot; high for the requester owning the counter.
- done_o  output  NUM_REQ  one-hot, one-cycle pulse when the owner's delay expires.
- busy_o  output  1  high whenever state ≠ IDLE.
- count_o  output  WIDTH  current counter value (debug/observe).

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE → COUNT:
  - Taken when any req_i bit is high.
  - Winner is the first requester with req high, searching from priority pointer ptr upward, modulo NUM_REQ.
  - Latch winner index and delay_i slice into count_o.
  - Set grant_o to the winner's one-hot bit.
- COUNT:
  - If count_o ≠ 0, decrement by 1.
  - If count_o == 0, go to DONE.
  - No wrap-around: the counter never decrements below 0.
- COUNT abort: if the owner's req_i drops, go to IDLE next edge.
  - grant_o and count_o clear; no done_o.
  - ptr still advances past the owner.
- DONE:
  - done_o carries the owner's bit for exactly this cycle.
  - grant_o is 0 and count_o is 0.
  - ptr = (owner+1) mod NUM_REQ; next state IDLE.
- delay_i is sampled only at the IDLE→COUNT edge. Later changes are ignored.
- A delay of 0 is legal: one COUNT cycle, then DONE.
- Non-owner req_i changes during COUNT/DONE are ignored until the next IDLE.
- Reset values: state IDLE, ptr 0, grant_o 0, done_o 0, busy_o 0, count_o 0.
- Reset mid-operation wins over all other events. No done_o is issued for the interrupted request.

## Timing
- Request sampled high in IDLE at edge k with delay D:
  - grant_o high for cycles k+1 … k+1+D (D+1 cycles).
  - count_o shows D, D-1, …, 0 over those cycles.
  - done_o pulses at cycle k+2+D.
  - IDLE at k+3+D; the earliest next grant is k+4+D.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The requester may deassert req_i in the done_o cycle or later. If req stays high in IDLE, that is a new request.
- Service is fair: with all requesters high, each is granted once per NUM_REQ arbitrations.

## Structure
- Package timer_arbiter_pkg holds the state enum (IDLE, COUNT, DONE) and the state width constant.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and binary index.
  - Purely combinational.
- The FSM, ptr register and down-counter live in timer_arbiter.

## Test plan
- Reset, then req_i=0001 with delay0=3 → grant_o=0001 for 4 cycles, count_o 3,2,1,0; done_o=0001 one cycle later; busy_o low after.
- req_i=1111 with all delays=1 held continuously → grant order 0,1,2,3,0; each done_o pulse single-cycle and one-hot.
- ptr=2 after serving req1, then req_i=1001 → requester 3 granted before 0.
- delay=0 on requester 2 → grant_o=0100 for 1 cycle; done_o=0100 on the next cycle.
- Abort and reset mid-count:
  - Requester 1, delay=15: drop req_i[1] at count 9 → IDLE next edge, no done_o, ptr=2.
  - Repeat with reset_i asserted at count 9 instead → all outputs 0 next edge, ptr=0.
